rxfifo2axis_ctrl: RTL

- Drains the RX read FIFOs (64-bit packet data FIFO "rf" and 32-bit byte-count FIFO "rcf") on the clk_fib side.
- Converts each packet into an AXI4-Stream master transfer sequence with tkeep and tlast.
- Sits directly downstream of the FMAC→FIFO RX write controller and feeds the AXIS bridge output.
- A 2-entry output skid buffer absorbs the 1-cycle FIFO read latency so tready backpressure never loses data.

---
 rtl/rxfifo2axis_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rxfifo2axis_ctrl.sv
// Drains the RX count/data FIFOs and replays each packet as an AXI4-Stream burst with tkeep/tlast.
// Optional packet/byte statistics are built when RXAXIS_PKTCNT_EN is defined.
module rxfifo2axis_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int BCNT_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk_fib,
  input  logic                  reset_,
  input  logic                  rdempty_rcf,
  output logic                  rden_rcf,
  input  logic [BCNT_WIDTH-1:0] dataout_rcf,
  input  logic                  rdempty_rf,
  output logic                  rden_rf,
  input  logic [DATA_WIDTH-1:0] dataout_rf,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
`ifdef RXAXIS_PKTCNT_EN
  input  logic                  stat_clr,
  output logic [31:0]           stat_pkt_cnt,
  output logic [31:0]           stat_byte_cnt,
`endif
  output logic                  err_zero_len
);

  // Extra pipeline stages beyond the FIFO read strobe; the FIFOs have one cycle of latency.
  localparam int STAGES = 0;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    RDCNT  = 5'b00010,
    LATCH  = 5'b00100,
    STREAM = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } beat_t;

  state_t                state, state_nxt;
  logic [15:0]           bcnt, bcnt_in;
  logic [13:0]           words_left;
  logic [1:0]            occ;
  beat_t [1:0]           sbuf;
  beat_t                 beat_in;
  logic [STAGES:0]       vld_pipe, last_pipe;
  logic                  accept, push, fin;
  logic [2:0]            slots;
  logic [KEEP_WIDTH-1:0] last_keep;
  logic                  unused_bits;

  assign bcnt_in     = dataout_rcf[BCNT_WIDTH-1:BCNT_WIDTH-16];
  assign unused_bits = ^dataout_rcf[BCNT_WIDTH-17:0];

  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = sbuf[0].data;
  assign m_axis_tkeep  = sbuf[0].keep;
  assign m_axis_tlast  = sbuf[0].last & m_axis_tvalid;
  assign accept        = m_axis_tvalid & m_axis_tready;
  assign push          = vld_pipe[STAGES];
  assign rden_rcf      = (state == RDCNT);

  // Occupancy the buffer will have when a read issued now lands; an accept frees a slot.
  assign slots   = {1'b0, occ} + {2'b0, push} - {2'b0, accept};
  assign rden_rf = (state == STREAM) & ~rdempty_rf & (words_left != 14'd0) & (slots < 3'd2);
  assign fin     = (words_left == 14'd0) & ~push & (occ == 2'd1) & accept;

  always_comb begin
    for (int i = 0; i < KEEP_WIDTH; i++)
      last_keep[i] = (bcnt[2:0] == 3'd0) || (3'(i) < bcnt[2:0]);
  end

  always_comb begin
    beat_in.data = dataout_rf;
    beat_in.last = last_pipe[STAGES];
    beat_in.keep = last_pipe[STAGES] ? last_keep : {KEEP_WIDTH{1'b1}};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!rdempty_rcf) state_nxt = RDCNT;
      RDCNT:   state_nxt = LATCH;
      LATCH:   state_nxt = (bcnt_in == 16'd0) ? IDLE : STREAM;
      STREAM:  if (fin) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_fib or negedge reset_) begin
    if (!reset_) begin
      state        <= IDLE;
      bcnt         <= '0;
      words_left   <= '0;
      err_zero_len <= 1'b0;
      vld_pipe     <= '0;
      last_pipe    <= '0;
    end else begin
      state        <= state_nxt;
      err_zero_len <= (state == LATCH) && (bcnt_in == 16'd0);
      vld_pipe     <= (STAGES+1)'({vld_pipe, rden_rf});
      last_pipe    <= (STAGES+1)'({last_pipe, words_left == 14'd1});
      if (state == LATCH) begin
        bcnt       <= bcnt_in;
        words_left <= {1'b0, bcnt_in[15:3]} + {13'd0, |bcnt_in[2:0]};
      end else if (rden_rf) begin
        words_left <= words_left - 14'd1;
      end
    end
  end

  // Two-entry skid buffer; sbuf[0] is the head presented on the stream.
  always_ff @(posedge clk_fib or negedge reset_) begin
    if (!reset_) begin
      sbuf <= '0;
      occ  <= 2'd0;
    end else begin
      unique case ({push, accept})
        2'b10: begin
          if (occ == 2'd0) sbuf[0] <= beat_in;
          else             sbuf[1] <= beat_in;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          sbuf[0] <= sbuf[1];
          occ     <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) sbuf[0] <= beat_in;
          else begin
            sbuf[0] <= sbuf[1];
            sbuf[1] <= beat_in;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RXAXIS_PKTCNT_EN
  always_ff @(posedge clk_fib or negedge reset_) begin
    if (!reset_) begin
      stat_pkt_cnt  <= '0;
      stat_byte_cnt <= '0;
    end else if (stat_clr) begin
      stat_pkt_cnt  <= '0;
      stat_byte_cnt <= '0;
    end else if (accept && m_axis_tlast) begin
      stat_pkt_cnt  <= stat_pkt_cnt + 32'd1;
      stat_byte_cnt <= stat_byte_cnt + {16'd0, bcnt};
    end
  end
`endif

endmodule
